// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED Hamming decoder: parity-width derivation,
// data-bit position mapping and a reference encoder.
package hamming_pkg;

    localparam int MAX_CODE_W = 64;

    function automatic int calc_par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    // Position of payload bit k: the k-th non-power-of-two index from 1 upward.
    function automatic int data_pos(input int k);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        while (cnt < k) begin
            pos++;
            if ((pos & (pos - 1)) != 0) cnt++;
        end
        return pos;
    endfunction

    function automatic logic [MAX_CODE_W-1:0] encode(input logic [MAX_CODE_W-1:0] data,
                                                     input int data_w);
        logic [MAX_CODE_W-1:0] code;
        logic                  p;
        int                    par_w;
        int                    code_w;
        par_w  = calc_par_w(data_w);
        code_w = data_w + par_w + 1;
        code   = '0;
        for (int k = 0; k < data_w; k++) code[data_pos(k)] = data[k];
        for (int j = 0; j < par_w; j++) begin
            p = 1'b0;
            for (int i = 1; i < code_w; i++) begin
                if (((i >> j) & 1) == 1) p = p ^ code[i];
            end
            code[1 << j] = p;
        end
        code[0] = ^code;
        return code;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int CODE_W = 16,
    parameter int PAR_W  = 4
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syndrome,
    output logic              parity
);

    function automatic logic [CODE_W-1:0] pos_mask(input int b);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 1; i < CODE_W; i++) m[i] = (((i >> b) & 1) == 1);
        return m;
    endfunction

    // Syndrome bit b covers every position whose index has bit b set.
    generate
        for (genvar gi = 0; gi < PAR_W; gi++) begin : g_syn
            localparam logic [CODE_W-1:0] MASK = pos_mask(gi);
            assign syndrome[gi] = ^(code & MASK);
        end
    endgenerate

    assign parity = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control.
// Optional error counters are built only when HAMMING_DEC_ERR_CNT_EN is defined.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk_decoder,
    input  logic              rst_decoder,
    input  logic [CODE_W-1:0] code_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [PAR_W-1:0]  syndrome_out,
    output logic              corrected,
    output logic              uncorrectable,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_corr_cnt,
    output logic [CNT_W-1:0]  err_uncorr_cnt
);

    localparam int SYN_N = 1 << PAR_W;

    function automatic logic [SYN_N-1:0] range_mask();
        logic [SYN_N-1:0] m;
        m = '0;
        for (int i = 0; i < SYN_N; i++) m[i] = (i < CODE_W);
        return m;
    endfunction

    // Syndromes that name a real bit position; the rest are uncorrectable.
    localparam logic [SYN_N-1:0] IN_RANGE = range_mask();

    logic              adv;
    logic [PAR_W-1:0]  syn_next;
    logic              par_next;
    logic              s1_valid_reg;
    logic [CODE_W-1:0] s1_code_reg;
    logic [PAR_W-1:0]  s1_syn_reg;
    logic              s1_par_reg;
    logic              corr_next;
    logic              unc_next;
    logic [DATA_W-1:0] data_next;
    logic              unused_code_bits;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    hamming_syndrome #(
        .CODE_W (CODE_W),
        .PAR_W  (PAR_W)
    ) u_syndrome (
        .code     (code_in),
        .syndrome (syn_next),
        .parity   (par_next)
    );

    assign corr_next = s1_par_reg && IN_RANGE[s1_syn_reg];
    assign unc_next  = s1_par_reg ? !IN_RANGE[s1_syn_reg] : (s1_syn_reg != '0);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
            localparam int POS = data_pos(gi);
            assign data_next[gi] = s1_code_reg[POS] ^ (corr_next && (s1_syn_reg == PAR_W'(POS)));
        end
    endgenerate

    // Parity positions are consumed by the syndrome only, not by data extraction.
    assign unused_code_bits = ^s1_code_reg;

    always_ff @(posedge clk_decoder or posedge rst_decoder) begin
        if (rst_decoder) begin
            s1_valid_reg  <= 1'b0;
            s1_code_reg   <= '0;
            s1_syn_reg    <= '0;
            s1_par_reg    <= 1'b0;
            out_valid     <= 1'b0;
            data_out      <= '0;
            syndrome_out  <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_code_reg <= code_in;
                s1_syn_reg  <= syn_next;
                s1_par_reg  <= par_next;
            end
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                data_out      <= data_next;
                syndrome_out  <= s1_syn_reg;
                corrected     <= corr_next;
                uncorrectable <= unc_next;
            end
        end
    end

`ifdef HAMMING_DEC_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    // Clear outranks a same-cycle increment; counts saturate rather than wrap.
    always_ff @(posedge clk_decoder or posedge rst_decoder) begin
        if (rst_decoder) begin
            err_corr_cnt   <= '0;
            err_uncorr_cnt <= '0;
        end else begin
            if (cnt_clr)
                err_corr_cnt <= '0;
            else if (out_xfer && corrected && (err_corr_cnt != CNT_MAX))
                err_corr_cnt <= err_corr_cnt + 1'b1;
            if (cnt_clr)
                err_uncorr_cnt <= '0;
            else if (out_xfer && uncorrectable && (err_uncorr_cnt != CNT_MAX))
                err_uncorr_cnt <= err_uncorr_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_corr_cnt   = '0;
    assign err_uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (DATA_W=11, CNT_W=2).
module tb_hamming_secded_decoder;
    import hamming_pkg::*;

    typedef struct packed {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        corr;
        logic        unc;
    } exp_t;

`ifdef HAMMING_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] code_in;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] data_out;
    logic [3:0]  syndrome_out;
    logic        corrected;
    logic        uncorrectable;
    logic        out_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [1:0]  err_corr_cnt;
    logic [1:0]  err_uncorr_cnt;

    int   checks = 0;
    int   errors = 0;
    int   rx_count = 0;
    exp_t sb[$];

    hamming_secded_decoder #(.DATA_W(11), .CNT_W(2)) dut (
        .clk_decoder    (clk),
        .rst_decoder    (rst),
        .code_in        (code_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_out       (data_out),
        .syndrome_out   (syndrome_out),
        .corrected      (corrected),
        .uncorrectable  (uncorrectable),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .cnt_clr        (cnt_clr),
        .err_corr_cnt   (err_corr_cnt),
        .err_uncorr_cnt (err_uncorr_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [10:0] d, input logic [3:0] s,
                                input logic c, input logic u);
        exp_t e;
        e.data = d;
        e.syn  = s;
        e.corr = c;
        e.unc  = u;
        return e;
    endfunction

    function automatic logic [1:0] ce(input int v);
        return CNT_EN ? 2'(v) : 2'd0;
    endfunction

    // Scoreboard side: every output transfer is popped and compared here.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!rst && out_valid && out_ready) begin
            checks++;
            got = mk(data_out, syndrome_out, corrected, uncorrectable);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got data=%h syn=%0d corr=%b unc=%b required none",
                         data_out, syndrome_out, corrected, uncorrectable);
            end else begin
                e = sb.pop_front();
                rx_count++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_bundle got data=%h syn=%0d corr=%b unc=%b required data=%h syn=%0d corr=%b unc=%b",
                             got.data, got.syn, got.corr, got.unc, e.data, e.syn, e.corr, e.unc);
                end else begin
                    $display("OUT data=%h syn=%0d corr=%b unc=%b", got.data, got.syn, got.corr, got.unc);
                end
            end
        end
    end

    // Called right after a rising edge; returns right after the accept edge.
    task automatic send(input logic [15:0] c, input exp_t e);
        int n;
        n = 0;
        code_in  = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=%b required 1", in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, data_out, syndrome_out, corrected, uncorrectable} !== {1'b0, 1'b1, 17'd0}) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b ready=%b data=%h syn=%0d corr=%b unc=%b required 0 1 0 0 0 0",
                     out_valid, in_ready, data_out, syndrome_out, corrected, uncorrectable);
        end
        checks++;
        if ({err_corr_cnt, err_uncorr_cnt} !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d %0d required 0 0", err_corr_cnt, err_uncorr_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean();
        send(16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%b required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, data_out, syndrome_out, corrected, uncorrectable} !== {1'b1, 11'h7FF, 4'd0, 2'b00}) begin
            errors++;
            $display("FAIL latency_out got valid=%b data=%h syn=%0d corr=%b unc=%b required 1 7ff 0 0 0",
                     out_valid, data_out, syndrome_out, corrected, uncorrectable);
        end
        drain();
    endtask

    task automatic test_corrected();
        send(16'hEFFF, mk(11'h7FF, 4'd12, 1'b1, 1'b0));
        send(16'h0001, mk(11'h000, 4'd0, 1'b1, 1'b0));
        drain();
        checks++;
        if (err_corr_cnt !== ce(2)) begin
            errors++;
            $display("FAIL corr_cnt got %0d required %0d", err_corr_cnt, ce(2));
        end
    endtask

    task automatic test_uncorrectable();
        send(16'h0048, mk(11'h005, 4'd5, 1'b0, 1'b1));
        drain();
        checks++;
        if (err_uncorr_cnt !== ce(1)) begin
            errors++;
            $display("FAIL uncorr_cnt got %0d required %0d", err_uncorr_cnt, ce(1));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] full;
        logic [15:0] words[8];
        exp_t        exps[8];
        logic [10:0] d;
        int          q;
        int          rx0;
        rx0 = rx_count;
        for (int i = 0; i < 8; i++) begin
            d    = 11'($urandom_range(0, 2047));
            full = encode(64'(d), 11);
            words[i] = full[15:0];
            if (i % 2 == 1) begin
                q = $urandom_range(0, 15);
                words[i][q] = ~words[i][q];
                exps[i] = mk(d, 4'(q), 1'b1, 1'b0);
            end else begin
                exps[i] = mk(d, 4'd0, 1'b0, 1'b0);
            end
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send(words[i], exps[i]);
            end
            begin
                logic [17:0] snap;
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                snap = {out_valid, data_out, syndrome_out, corrected, uncorrectable};
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({out_valid, data_out, syndrome_out, corrected, uncorrectable} !== snap || in_ready !== 1'b0
                        || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_freeze got %h ready=%b required %h ready=0 valid=1",
                                 {out_valid, data_out, syndrome_out, corrected, uncorrectable}, in_ready, snap);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (rx_count - rx0 != 8) begin
            errors++;
            $display("FAIL stream_count got %0d required 8", rx_count - rx0);
        end
    endtask

    task automatic test_counters();
        int n;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if ({err_corr_cnt, err_uncorr_cnt} !== 4'd0) begin
            errors++;
            $display("FAIL clr_only got %0d %0d required 0 0", err_corr_cnt, err_uncorr_cnt);
        end
        for (int i = 0; i < 5; i++) send(16'hFFFF ^ (16'd1 << (i + 1)), mk(11'h7FF, 4'(i + 1), 1'b1, 1'b0));
        drain();
        checks++;
        if (err_corr_cnt !== ce(3)) begin
            errors++;
            $display("FAIL corr_saturate got %0d required %0d", err_corr_cnt, ce(3));
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        send(16'h0001, mk(11'h000, 4'd0, 1'b1, 1'b0));
        drain();
        checks++;
        if (err_corr_cnt !== ce(1)) begin
            errors++;
            $display("FAIL corr_after_clr got %0d required %0d", err_corr_cnt, ce(1));
        end
        send(16'h0001, mk(11'h000, 4'd0, 1'b1, 1'b0));
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if (err_corr_cnt !== 2'd0 || n >= 20) begin
            errors++;
            $display("FAIL clr_priority got %0d required 0", err_corr_cnt);
        end
        drain();
    endtask

    task automatic test_reset_in_flight();
        send(16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        send(16'hEFFF, mk(11'h7FF, 4'd12, 1'b1, 1'b0));
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({out_valid, in_ready, data_out, err_corr_cnt, err_uncorr_cnt} !== {1'b0, 1'b1, 15'd0}) begin
            errors++;
            $display("FAIL reset_flight got valid=%b ready=%b data=%h cnt=%0d %0d required 0 1 0 0 0",
                     out_valid, in_ready, data_out, err_corr_cnt, err_uncorr_cnt);
        end
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_output got out_valid=%b required 0", out_valid);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        code_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        test_reset();
        test_clean();
        test_corrected();
        test_uncorrectable();
        test_back_to_back();
        test_counters();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 11: payload bits per codeword, legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL derive localparams PAR_W (smallest p with 2^p >= DATA_W+p+1) and CODE_W = DATA_W+PAR_W+1; defaults give PAR_W=4 and CODE_W=16.
REQ-004 SHALL have port clk_decoder  in  1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_decoder  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port code_in  in  CODE_W: received codeword; bit i is Hamming position i, and bit 0 is overall parity.
REQ-007 SHALL have port in_valid  in  1: code_in is valid this cycle.
REQ-008 SHALL have port in_ready  out  1: the block accepts a word this cycle.
REQ-009 SHALL have port data_out  out  DATA_W: corrected payload.
REQ-010 SHALL have port syndrome_out  out  PAR_W: computed syndrome.
REQ-011 SHALL have port corrected  out  1: a single-bit error was corrected.
REQ-012 SHALL have port uncorrectable  out  1: a double error, or a syndrome outside the codeword, was detected.
REQ-013 SHALL have port out_valid  out  1: the output bundle is valid.
REQ-014 SHALL have port out_ready  in  1: the consumer takes the bundle this cycle.
REQ-015 SHALL have port cnt_clr  in  1: synchronous clear of both counters.
REQ-016 SHALL have ports err_corr_cnt and err_uncorr_cnt  out  CNT_W each: error counters.

Function
REQ-017 SHALL place parity at power-of-two positions and data, LSB first, at the remaining positions 3,5,6,7,9,... in ascending order; parity is even.
REQ-018 SHALL compute S as the XOR of the indices of all set bits at positions 1..CODE_W-1, and P as the XOR of all CODE_W bits.
REQ-019 SHALL classify P=0,S=0 as clean, with corrected=0 and uncorrectable=0.
REQ-020 SHALL, when P=1 and S<=CODE_W-1, invert bit S and set corrected=1; S=0 means only the overall-parity bit was wrong, so data is unchanged.
REQ-021 SHALL classify P=0,S!=0 as uncorrectable, and also P=1,S>CODE_W-1; in both cases data_out carries the raw, uncorrected data bits.
REQ-022 SHALL use a two-stage pipeline: stage 1 registers the codeword with S and P, and stage 2 registers the corrected outputs; latency is 2 cycles from the accept edge to out_valid.
REQ-023 SHALL use a global advance enable adv = !out_valid || out_ready, with in_ready = adv; an input transfer is in_valid && in_ready.
REQ-024 SHALL, while out_valid=1 and out_ready=0, hold every output and all stage-1 contents stable.
REQ-025 SHALL sustain a throughput of one word per cycle when out_ready stays 1; bubbles are not collapsed.
REQ-026 SHALL increment each counter only on an output transfer (out_valid && out_ready) whose bundle has the matching flag set.
REQ-027 SHALL saturate each counter at 2^CNT_W-1, with no wrap.
REQ-028 SHALL, when cnt_clr and an increment fall in the same cycle, give the clear priority, so the counter becomes 0.

Reset
REQ-029 SHALL, while rst_decoder=1, force out_valid=0, both stage valids 0, data_out=0, syndrome_out=0, corrected=0, uncorrectable=0 and both counters 0; in_ready is then 1.
REQ-030 SHALL discard any words in flight on reset mid-stream; no output transfer occurs for them after release.

Configuration
REQ-031 SHALL implement the counters, counter saturation and cnt_clr only when macro HAMMING_DEC_ERR_CNT_EN is defined.
REQ-032 SHALL, without HAMMING_DEC_ERR_CNT_EN, keep both counter ports but tie them to 0, ignore cnt_clr, and leave the decode path unchanged.

Structure
REQ-033 SHALL place in package hamming_pkg: the PAR_W derivation function, the data-position mapping function, and the encode reference function used by the bench.
REQ-034 SHALL use one combinational sub-module, hamming_syndrome, which computes S and P for parameter CODE_W.

Verification
REQ-035 SHALL cover: DATA_W=11, code_in=16'hFFFF -> data_out=11'h7FF, syndrome 0, both flags 0, out_valid 2 cycles after accept.
REQ-036 SHALL cover: code_in=16'hEFFF (bit 12 flipped) -> data_out=11'h7FF, syndrome_out=12, corrected=1; and 16'h0001 -> data_out=0, syndrome 0, corrected=1.
REQ-037 SHALL cover: code_in=16'h0048 (bits 3 and 6) -> syndrome_out=5, uncorrectable=1, data_out=raw data (11'h005), err_uncorr_cnt=1.
REQ-038 SHALL cover: a back-to-back stream of 8 words with out_ready held low for 3 cycles mid-stream -> all outputs frozen, no loss or duplication, order preserved.
REQ-039 SHALL cover: CNT_W=2 with 5 correctable words -> err_corr_cnt saturates at 3; cnt_clr asserted together with an increment -> counter reads 0.
REQ-040 SHALL cover: rst_decoder pulsed with two words in flight -> out_valid=0 immediately, no stale output after release, counters 0.
